// File: rtl/qadd_pkg.sv
// ============================================================================
// Module      : qadd_pkg
// Description : Shared constants for the pipelined saturating/wrapping adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package qadd_pkg;

  // Default geometry of the pipeline
  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_STAGES = 3;

  // Legal parameter ranges
  localparam int MIN_WIDTH  = 2;
  localparam int MAX_WIDTH  = 32;
  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 8;

  // Per-transaction overflow handling mode carried on the sat input
  localparam logic SAT_WRAP  = 1'b0;
  localparam logic SAT_CLAMP = 1'b1;

  // Width of the occupancy count (holds 0..MAX_STAGES)
  localparam int OCC_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/qadd_stage.sv
// ============================================================================
// Module      : qadd_stage
// Description : One accumulate stage: adds the carried increment to the
//               running sum, folds the carry into a sticky overflow flag and
//               clamps to all-ones when the transaction is in saturate mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qadd_stage
  import qadd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sat_i,
  input  logic             ovf_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] b_o,
  output logic             sat_o,
  output logic             ovf_o
);

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;

  logic             valid_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic             sat_q;
  logic             ovf_q;

  // Extra top bit captures the carry out of this stage's addition
  assign sum_w = {1'b0, acc_i} + {1'b0, b_i};

  // Sticky overflow; once a clamping transaction has overflowed it stays pinned at all-ones
  always_comb begin
    ovf_d = ovf_i | sum_w[WIDTH];
    acc_d = sum_w[WIDTH-1:0];
    if ((sat_i == SAT_CLAMP) && ovf_d) begin
      acc_d = {WIDTH{1'b1}};
    end
  end

  // Stage register: advances only on the global enable, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      acc_q   <= acc_d;
      b_q     <= b_i;
      sat_q   <= sat_i;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign acc_o   = acc_q;
  assign b_o     = b_q;
  assign sat_o   = sat_q;
  assign ovf_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/qadd_pipe.sv
// ============================================================================
// Module      : qadd_pipe
// Description : Pipelined adder computing a + (STAGES-1)*b with per-
//               transaction wrap/saturate mode, valid/ready handshaking and
//               a global stall enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qadd_pipe
  import qadd_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     c,
  output logic                 ovf,
  output logic [OCC_WIDTH-1:0] occupancy
);

  // Index 0 is the capture stage; indices 1..STAGES-1 are adder stages
  logic [STAGES-1:0]            vld_w;
  logic [STAGES-1:0][WIDTH-1:0] acc_w;
  logic [STAGES-1:0][WIDTH-1:0] b_w;
  logic [STAGES-1:0]            sat_w;
  logic [STAGES-1:0]            ovf_w;

  logic                 en_w;
  logic [OCC_WIDTH-1:0] occ_d;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_acc_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_sat_q;

  // Whole pipe moves together; only a held, unconsumed result stalls it
  assign en_w     = ~vld_w[STAGES-1] | out_ready;
  assign in_ready = en_w;

  // Capture stage: latch operands and mode; no addition happens here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_acc_q   <= '0;
      s1_b_q     <= '0;
      s1_sat_q   <= 1'b0;
    end else if (en_w) begin
      s1_valid_q <= in_valid;
      s1_acc_q   <= a;
      s1_b_q     <= b;
      s1_sat_q   <= sat;
    end
  end

  assign vld_w[0] = s1_valid_q;
  assign acc_w[0] = s1_acc_q;
  assign b_w[0]   = s1_b_q;
  assign sat_w[0] = s1_sat_q;
  assign ovf_w[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      qadd_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_w),
        .valid_i (vld_w[gi-1]),
        .acc_i   (acc_w[gi-1]),
        .b_i     (b_w[gi-1]),
        .sat_i   (sat_w[gi-1]),
        .ovf_i   (ovf_w[gi-1]),
        .valid_o (vld_w[gi]),
        .acc_o   (acc_w[gi]),
        .b_o     (b_w[gi]),
        .sat_o   (sat_w[gi]),
        .ovf_o   (ovf_w[gi])
      );
    end
  endgenerate

  // The final stage's carried increment and mode have no consumer
  logic unused_tail_w;
  assign unused_tail_w = ^{b_w[STAGES-1], sat_w[STAGES-1]};

  // Count valid stages; reflects the async-cleared valid bits immediately
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + {{(OCC_WIDTH-1){1'b0}}, vld_w[i]};
    end
  end

  assign occupancy = occ_d;
  assign out_valid = vld_w[STAGES-1];
  assign c         = acc_w[STAGES-1];
  assign ovf       = ovf_w[STAGES-1];

endmodule

`default_nettype wire

// File: doc/qadd_pipe.md
QADD_PIPE -- requirements
Module: qadd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits, legal 2..32.
REQ-002 SHALL have parameter STAGES, default 3, number of pipeline registers, legal 2..8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers a transaction.
REQ-006 SHALL have port in_ready  output  1  block accepts a transaction this cycle.
REQ-007 SHALL have port a  input  WIDTH  unsigned base operand.
REQ-008 SHALL have port b  input  WIDTH  unsigned increment operand.
REQ-009 SHALL have port sat  input  1  per-transaction mode: 1 saturate, 0 wrap.
REQ-010 SHALL have port out_valid  output  1  result c is valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port c  output  WIDTH  result.
REQ-013 SHALL have port ovf  output  1  true-sum overflow flag for this result.
REQ-014 SHALL have port occupancy  output  4  count of valid stages in the pipeline.

Function
REQ-015 SHALL compute, per transaction, the true sum S = a + (STAGES-1)*b.
REQ-016 SHALL capture a, b and sat into stage 1; each stage 2..STAGES SHALL add the carried b once.
REQ-017 SHALL track carry-out per stage; ovf SHALL be the sticky OR of all carries of the transaction.
REQ-018 With sat=0, c SHALL be S mod 2^WIDTH.
REQ-019 With sat=1 and ovf=1, c SHALL be 2^WIDTH-1, and saturation SHALL persist through later stages.
REQ-020 Pipeline SHALL advance (global enable) when out_valid=0 or out_ready=1.
REQ-021 in_ready SHALL equal the advance enable; a transfer occurs when in_valid and in_ready are both 1.
REQ-022 With no stall, a transaction accepted at edge k SHALL present out_valid=1 after edge k+STAGES-1.
REQ-023 Throughput SHALL be one transaction per cycle when out_ready is held at 1.
REQ-024 While stalled, all stage contents, c, ovf and out_valid SHALL hold unchanged; no transaction SHALL be lost or duplicated.
REQ-025 A stage with no valid transaction (bubble) SHALL propagate as invalid; c of an invalid output is don't-care.
REQ-026 occupancy SHALL equal the number of stages holding a valid transaction, range 0..STAGES.
REQ-027 Output order SHALL equal acceptance order.

Reset
REQ-028 On rst=1, all stage valid bits, c, ovf and occupancy SHALL clear to 0 immediately, without waiting for clk.
REQ-029 in_ready SHALL be 1 during and after reset; transactions in flight at reset SHALL be discarded.
REQ-030 The first acceptance after reset SHALL occur on the first clk edge with rst=0 and in_valid=1.

Structure
REQ-031 Package qadd_pkg SHALL hold default WIDTH/STAGES constants, STAGES bounds, and the sat-mode encoding constants.
REQ-032 One sub-module qadd_stage (register + conditional add + carry/saturation logic) SHALL be instantiated STAGES-1 times.
REQ-033 The pipeline SHALL use no combinational path from in_valid to out_valid.

Verification (WIDTH=8, STAGES=3)
REQ-034 Basic: a=5, b=3, sat=0, out_ready=1 -> c=11, ovf=0, out_valid 2 edges after acceptance.
REQ-035 Wrap: a=250, b=4, sat=0 -> c=2, ovf=1; saturate: same operands with sat=1 -> c=255, ovf=1.
REQ-036 Throughput: 8 back-to-back transactions (a=i, b=1) -> 8 consecutive results c=i+2, in order, no gaps.
REQ-037 Backpressure: out_ready=0 for 5 cycles with a full pipe -> in_ready=0, occupancy=3, c held; on release, all results delivered in order.
REQ-038 Reset mid-stream: assert rst between clk edges with occupancy=2 -> out_valid=0, occupancy=0, in_ready=1 immediately; the next accepted a=1, b=1 -> c=3.
